// File: rtl/hyperbus_wb_bridge_pkg.sv
// Shared types for the Wishbone-to-hyperbus_fifo bridge.
// Holds the one-hot FSM encoding, the command codes and the full byte mask.
package hyperbus_wb_bridge_pkg;

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_WR_WAIT  = 5'b00010,
    S_WR_GUARD = 5'b00100,
    S_RD_WAIT  = 5'b01000,
    S_DONE     = 5'b10000
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [3:0] SEL_FULL = 4'hF;

endpackage

// File: rtl/hyperbus_wb_bridge_if.sv
// Wishbone B4 classic bus between a master and the bridge slave.
// Ports: adr/dat/sel/we/cyc/stb from the master; dat_o/ack/err back.
interface hyperbus_wb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [3:0]            wb_sel_i;
  logic                  wb_we_i;
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_ack_o;
  logic                  wb_err_o;

  modport master (
    output wb_adr_i,
    output wb_dat_i,
    output wb_sel_i,
    output wb_we_i,
    output wb_cyc_i,
    output wb_stb_i,
    input  wb_dat_o,
    input  wb_ack_o,
    input  wb_err_o
  );

  modport slave (
    input  wb_adr_i,
    input  wb_dat_i,
    input  wb_sel_i,
    input  wb_we_i,
    input  wb_cyc_i,
    input  wb_stb_i,
    output wb_dat_o,
    output wb_ack_o,
    output wb_err_o
  );

endinterface

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone classic slave turning single 32-bit accesses into rrq/wrq pulses
// for hyperbus_fifo. Ports: clk, rst_n, wb (slave), rrq, wrq, adr_o,
// tx_dat_o, tx_ready, rx_dat_i, rx_valid. All outputs are registered.
module hyperbus_wb_bridge
  import hyperbus_wb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hyperbus_wb_bridge_if.slave   wb,
  output logic                  rrq,
  output logic                  wrq,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] tx_dat_o,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_dat_i,
  input  logic                  rx_valid
);

  localparam logic [3:0]  GUARD_LD = 4'(GUARD_CYCLES);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [3:0]  guard;
  logic [15:0] tmo;
  logic        req;

  // Byte address bit 0 is dropped: the FIFO takes 16-bit word addresses.
  logic unused_adr0;
  assign unused_adr0 = wb.wb_adr_i[0];

  assign req = wb.wb_cyc_i & wb.wb_stb_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rrq         <= 1'b0;
      wrq         <= 1'b0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      wb.wb_dat_o <= '0;
      adr_o       <= '0;
      tx_dat_o    <= '0;
      guard       <= '0;
      tmo         <= '0;
    end else begin
      rrq         <= 1'b0;
      wrq         <= 1'b0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      // Overwritten by IDLE; counts in every wait state.
      tmo         <= tmo + 16'd1;
      unique case (1'b1)
        (state == S_IDLE): begin
          tmo <= '0;
          if (req) begin
            if (wb.wb_sel_i != SEL_FULL) begin
              wb.wb_err_o <= 1'b1;
              state       <= S_DONE;
            end else begin
              adr_o <= {1'b0, wb.wb_adr_i[ADDR_WIDTH-1:1]};
              if (wb.wb_we_i == CMD_WRITE) begin
                tx_dat_o <= wb.wb_dat_i;
                state    <= S_WR_WAIT;
              end else begin
                rrq   <= 1'b1;
                state <= S_RD_WAIT;
              end
            end
          end
        end
        (state == S_WR_WAIT): begin
          if (!wb.wb_cyc_i) begin
            state <= S_IDLE;
          end else if (tx_ready) begin
            wrq   <= 1'b1;
            guard <= GUARD_LD;
            state <= S_WR_GUARD;
          end else if (tmo == TMO_LAST) begin
            wb.wb_err_o <= 1'b1;
            state       <= S_DONE;
          end
        end
        (state == S_WR_GUARD): begin
          // tx_ready is stale while the FIFO flag crosses domains.
          if (!wb.wb_cyc_i) begin
            state <= S_IDLE;
          end else if (guard != 4'd0) begin
            guard <= guard - 4'd1;
            if (tmo == TMO_LAST) begin
              wb.wb_err_o <= 1'b1;
              state       <= S_DONE;
            end
          end else if (tx_ready) begin
            wb.wb_ack_o <= 1'b1;
            state       <= S_DONE;
          end else if (tmo == TMO_LAST) begin
            wb.wb_err_o <= 1'b1;
            state       <= S_DONE;
          end
        end
        (state == S_RD_WAIT): begin
          if (!wb.wb_cyc_i) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            wb.wb_dat_o <= rx_dat_i;
            wb.wb_ack_o <= 1'b1;
            state       <= S_DONE;
          end else if (tmo == TMO_LAST) begin
            wb.wb_err_o <= 1'b1;
            state       <= S_DONE;
          end
        end
        (state == S_DONE): begin
          // One cycle lets the master drop the strobe it just saw ended.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
